// File: rtl/core_pkg.sv
// Shared definitions for the core instruction bus: field positions, idle word
// and the sequencer state set. The core's instruction decoder imports this too.
package core_pkg;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;

  localparam int ACC_BIT      = 33;
  localparam int CEN_PMEM_BIT = 32;
  localparam int WEN_PMEM_BIT = 31;
  localparam int A_PMEM_LSB   = 20;
  localparam int CEN_XMEM_BIT = 19;
  localparam int WEN_XMEM_BIT = 18;
  localparam int A_XMEM_LSB   = 7;
  localparam int OFIFO_RD_BIT = 6;
  localparam int IFIFO_WR_BIT = 5;
  localparam int IFIFO_RD_BIT = 4;
  localparam int L0_RD_BIT    = 3;
  localparam int L0_WR_BIT    = 2;
  localparam int EXECUTE_BIT  = 1;
  localparam int LOAD_BIT     = 0;

  // Both memories deselected and write-disabled, every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1800C0000;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_GAP1, S_X_L0, S_EXEC, S_GAP2, S_DRAIN, S_DONE
  } state_t;

  function automatic state_t next_phase(input state_t st);
    case (st)
      S_IDLE:   return S_W_L0;
      S_W_L0:   return S_W_LOAD;
      S_W_LOAD: return S_GAP1;
      S_GAP1:   return S_X_L0;
      S_X_L0:   return S_EXEC;
      S_EXEC:   return S_GAP2;
      S_GAP2:   return S_DRAIN;
      S_DRAIN:  return S_DONE;
      default:  return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/inst_seq_drain.sv
// OFIFO-to-PMEM drain handshake: counts psum rows moved so far and produces
// the read strobe and PMEM address for the row the next edge will issue.
module inst_seq_drain
  import core_pkg::*;
#(
  parameter int len_nij = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              ofifo_valid,
  input  logic [ADDR_W-1:0] p_base,
  output logic              fire,
  output logic              last,
  output logic [ADDR_W-1:0] a_pmem
);

  localparam int DW = $clog2(len_nij + 1);

  logic [DW-1:0] cnt_reg;

  assign last   = (cnt_reg == DW'(len_nij));
  assign fire   = en && ofifo_valid && !last;
  // Modulo-2^11 add: a base near the top of PMEM wraps to address 0.
  assign a_pmem = p_base + ADDR_W'(cnt_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (!en) begin
      cnt_reg <= '0;
    end else if (fire) begin
      cnt_reg <= cnt_reg + DW'(1);
    end
  end

endmodule

// File: rtl/inst_seq.sv
// Kernel-pass instruction sequencer: walks weight load, activation load,
// execute and psum drain, emitting one registered core instruction per cycle.
module inst_seq
  import core_pkg::*;
#(
  parameter int          col     = 8,
  parameter int          len_nij = 64,
  parameter int          gap     = 10,
  parameter logic [10:0] w_base  = 11'b10000000000,
  parameter logic [10:0] x_base  = 11'b00000000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] p_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int LEN_A   = (2 * col + 1 > len_nij + 1) ? 2 * col + 1 : len_nij + 1;
  localparam int MAX_LEN = (LEN_A > gap) ? LEN_A : gap;
  localparam int CW      = $clog2(MAX_LEN + 1);

  state_t            state_reg;
  logic [CW-1:0]     ctr_reg;
  logic [INST_W-1:0] inst_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [ADDR_W-1:0] p_base_reg;

  logic              drain_en;
  logic              drain_fire;
  logic              drain_last;
  logic [ADDR_W-1:0] drain_addr;
  logic [INST_W-1:0] drain_inst;

  // Counter value loaded on entry; the phase ends when it has counted to zero.
  function automatic logic [CW-1:0] phase_last(input state_t st);
    case (st)
      S_W_L0:          return CW'(col);
      S_W_LOAD:        return CW'(2 * col);
      S_GAP1, S_GAP2:  return CW'(gap - 1);
      S_X_L0, S_EXEC:  return CW'(len_nij);
      default:         return '0;
    endcase
  endfunction

  function automatic logic [INST_W-1:0] phase_inst(input state_t st, input logic [CW-1:0] c);
    logic [INST_W-1:0] v;
    int idx;
    v   = IDLE_INST;
    idx = 0;
    case (st)
      S_W_L0: begin
        idx = col - int'(c);
        if (idx > col - 1) idx = col - 1;
        v[CEN_XMEM_BIT] = 1'b0;
        v[L0_WR_BIT]    = 1'b1;
        v[A_XMEM_LSB +: ADDR_W] = w_base + ADDR_W'(idx);
      end
      S_W_LOAD: begin
        v[L0_RD_BIT] = 1'b1;
        v[LOAD_BIT]  = (c != CW'(2 * col));
      end
      S_X_L0: begin
        idx = len_nij - int'(c);
        if (idx > len_nij - 1) idx = len_nij - 1;
        v[CEN_XMEM_BIT] = 1'b0;
        v[L0_WR_BIT]    = 1'b1;
        v[A_XMEM_LSB +: ADDR_W] = x_base + ADDR_W'(idx);
      end
      S_EXEC: begin
        v[L0_RD_BIT]   = 1'b1;
        v[EXECUTE_BIT] = (c != CW'(len_nij));
      end
      default: ;
    endcase
    v[ACC_BIT]      = 1'b0;
    v[IFIFO_WR_BIT] = 1'b0;
    v[IFIFO_RD_BIT] = 1'b0;
    return v;
  endfunction

  // The drain block is armed on the last GAP2 cycle so the entry edge can issue row 0.
  assign drain_en = (state_reg == S_DRAIN) || (state_reg == S_GAP2 && ctr_reg == '0);

  inst_seq_drain #(.len_nij(len_nij)) u_drain (
    .clk         (clk),
    .reset       (reset),
    .en          (drain_en),
    .ofifo_valid (ofifo_valid),
    .p_base      (p_base_reg),
    .fire        (drain_fire),
    .last        (drain_last),
    .a_pmem      (drain_addr)
  );

  always_comb begin
    drain_inst = IDLE_INST;
    if (drain_fire) begin
      drain_inst[OFIFO_RD_BIT] = 1'b1;
      drain_inst[CEN_PMEM_BIT] = 1'b0;
      drain_inst[WEN_PMEM_BIT] = 1'b0;
      drain_inst[A_PMEM_LSB +: ADDR_W] = drain_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      ctr_reg    <= '0;
      inst_reg   <= IDLE_INST;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      p_base_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            p_base_reg <= p_base;
            state_reg  <= S_W_L0;
            ctr_reg    <= phase_last(S_W_L0);
            inst_reg   <= phase_inst(S_W_L0, phase_last(S_W_L0));
            busy_reg   <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_last) begin
            state_reg <= S_DONE;
            inst_reg  <= IDLE_INST;
            done_reg  <= 1'b1;
          end else begin
            inst_reg <= drain_inst;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          inst_reg  <= IDLE_INST;
          busy_reg  <= 1'b0;
        end
        default: begin
          if (ctr_reg != '0) begin
            ctr_reg  <= ctr_reg - CW'(1);
            inst_reg <= phase_inst(state_reg, ctr_reg - CW'(1));
          end else begin
            state_reg <= next_phase(state_reg);
            ctr_reg   <= phase_last(next_phase(state_reg));
            inst_reg  <= (next_phase(state_reg) == S_DRAIN) ? drain_inst
                       : phase_inst(next_phase(state_reg), phase_last(next_phase(state_reg)));
          end
        end
      endcase
    end
  end

  assign inst = inst_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_inst_seq.sv
// Directed bench for inst_seq at default parameters: reset, full passes,
// drain stalls, PMEM address wrap, ignored re-starts and mid-pass reset.
module tb_inst_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] p_base;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [33:0] IDLE_W = 34'h1800C0000;

  inst_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .p_base      (p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full pass from IDLE; expected words follow the hand-derived cycle map
  // (k = cycles since the accepting edge): W_L0 0-8, W_LOAD 9-25, GAP1 26-35,
  // X_L0 36-100, EXEC 101-165, GAP2 166-175, DRAIN from 176.
  task automatic run_pass(input logic [10:0] pb, input bit stall, input bit repulse,
                          input string name, output int done_k);
    logic [33:0] exp;
    logic [10:0] a;
    logic        vprev;
    logic        v;
    bit          finished;
    bit          in_done;
    int          vcount, nload, nexec, nwr;
    vcount = 0; nload = 0; nexec = 0; nwr = 0;
    vprev = 1'b1; finished = 1'b0; done_k = -1;
    start = 1'b1; p_base = pb; ofifo_valid = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 1200 && !finished; k++) begin
      in_done = 1'b0;
      exp = IDLE_W;
      if (k <= 8) begin
        exp[19] = 1'b0; exp[2] = 1'b1;
        a = 11'h400 + 11'(k < 7 ? k : 7);
        exp[17:7] = a;
      end else if (k <= 25) begin
        exp[3] = 1'b1; exp[0] = (k >= 10);
      end else if (k <= 35) begin
        exp = IDLE_W;
      end else if (k <= 100) begin
        exp[19] = 1'b0; exp[2] = 1'b1;
        a = 11'(k - 36 < 63 ? k - 36 : 63);
        exp[17:7] = a;
      end else if (k <= 165) begin
        exp[3] = 1'b1; exp[1] = (k >= 102);
      end else if (k <= 175) begin
        exp = IDLE_W;
      end else if (vcount == 64) begin
        in_done = 1'b1;
      end else if (vprev) begin
        exp[6] = 1'b1; exp[32] = 1'b0; exp[31] = 1'b0;
        a = pb + 11'(vcount);
        exp[30:20] = a;
        vcount++;
      end
      n_tests++;
      if (inst !== exp) begin
        n_fail++;
        $display("FAIL %s inst k=%0d: got %h want %h", name, k, inst, exp);
      end
      n_tests++;
      if (done !== in_done || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s flags k=%0d: got done=%b busy=%b want done=%b busy=1",
                 name, k, done, busy, in_done);
      end
      nload += int'(inst[0]);
      nexec += int'(inst[1]);
      if (inst[6] && !inst[32]) nwr++;
      start = repulse && (k == 120 || in_done);
      v = stall ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
      ofifo_valid = v;
      vprev = v;
      if (in_done) begin
        finished = 1'b1;
        done_k = k;
      end
      step();
    end
    start = 1'b0;
    n_tests++;
    if (!finished) begin
      n_fail++;
      $display("FAIL %s timeout: no done within 1200 cycles, want done", name);
    end
    n_tests++;
    if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got inst=%h busy=%b done=%b want inst=%h busy=0 done=0",
               name, inst, busy, done, IDLE_W);
    end
    n_tests++;
    if (nload != 16 || nexec != 64 || nwr != 64) begin
      n_fail++;
      $display("FAIL %s counts: got load=%0d exec=%0d writes=%0d want 16 64 64",
               name, nload, nexec, nwr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; p_base = 11'h055; ofifo_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: got inst=%h busy=%b done=%b want inst=%h busy=0 done=0",
                 i, inst, busy, done, IDLE_W);
      end
    end
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle cyc=%0d: got inst=%h busy=%b done=%b want inst=%h busy=0 done=0",
                 i, inst, busy, done, IDLE_W);
      end
    end
  endtask

  task automatic test_default_pass();
    int dk;
    run_pass(11'h000, 1'b0, 1'b0, "default_pass", dk);
    n_tests++;
    if (dk != 240) begin
      n_fail++;
      $display("FAIL default_pass latency: got done at k=%0d want k=240", dk);
    end
  endtask

  task automatic test_drain_stall();
    int dk;
    run_pass(11'h100, 1'b1, 1'b0, "drain_stall", dk);
    n_tests++;
    if (dk <= 240) begin
      n_fail++;
      $display("FAIL drain_stall latency: got done at k=%0d want k>240", dk);
    end
  endtask

  task automatic test_pbase_wrap();
    int dk;
    run_pass(11'h7F0, 1'b0, 1'b0, "pbase_wrap", dk);
  endtask

  task automatic test_restart_ignored();
    int dk;
    run_pass(11'h020, 1'b0, 1'b1, "restart_ignored", dk);
    n_tests++;
    if (dk != 240) begin
      n_fail++;
      $display("FAIL restart_ignored latency: got done at k=%0d want k=240", dk);
    end
  endtask

  task automatic test_reset_midpass();
    logic [33:0] exp;
    int dk;
    start = 1'b1; p_base = 11'h000; ofifo_valid = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 66; k++) step();
    exp = IDLE_W;
    exp[19] = 1'b0; exp[2] = 1'b1; exp[17:7] = 11'd30;
    n_tests++;
    if (inst !== exp) begin
      n_fail++;
      $display("FAIL midpass_pos: got inst=%h want %h", inst, exp);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midpass_reset: got inst=%h busy=%b done=%b want inst=%h busy=0 done=0",
               inst, busy, done, IDLE_W);
    end
    reset = 1'b1;
    run_pass(11'h000, 1'b0, 1'b0, "after_reset_pass", dk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; p_base = '0; ofifo_valid = 1'b0;
    test_reset();
    test_default_pass();
    test_drain_stall();
    test_pbase_wrap();
    test_restart_ignored();
    test_reset_midpass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
